// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path: opcodes,
// ALU operation codes, datapath mux selects, FSM states and instruction classes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYP  = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_LUI   = 3'b110;
    localparam logic [2:0] ALU_FUNCT = 3'b111;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] REGDST_RT  = 2'b00;
    localparam logic [1:0] REGDST_RD  = 2'b01;
    localparam logic [1:0] REGDST_R31 = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_EXEC_R   = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_ALU_WB   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11
    } state_e;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_MEM = 3'd2,
        CLS_BR  = 3'd3,
        CLS_J   = 3'd4
    } instr_cls_e;

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational opcode classifier: instruction class, legality, immediate
// extension mode and the ALU operation used by I-type execution.
module mc_opcode_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]  op_i,
    output instr_cls_e  cls_o,
    output logic        legal_o,
    output logic        ext_ctr_o,
    output logic [2:0]  alu_op_o
);

    always_comb begin
        cls_o     = CLS_R;
        legal_o   = 1'b1;
        ext_ctr_o = 1'b0;
        alu_op_o  = ALU_ADD;
        case (op_i)
            OP_RTYP:          cls_o = CLS_R;
            OP_ADDI, OP_ADDIU: begin
                cls_o     = CLS_I;
                ext_ctr_o = 1'b1;
            end
            OP_SLTI, OP_SLTIU: begin
                cls_o     = CLS_I;
                ext_ctr_o = 1'b1;
                alu_op_o  = ALU_SUB;
            end
            OP_ANDI: begin
                cls_o    = CLS_I;
                alu_op_o = ALU_AND;
            end
            OP_ORI: begin
                cls_o    = CLS_I;
                alu_op_o = ALU_OR;
            end
            OP_XORI: begin
                cls_o    = CLS_I;
                alu_op_o = ALU_XOR;
            end
            OP_LUI: begin
                cls_o    = CLS_I;
                alu_op_o = ALU_LUI;
            end
            OP_LW, OP_SW: begin
                cls_o     = CLS_MEM;
                ext_ctr_o = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                cls_o     = CLS_BR;
                ext_ctr_o = 1'b1;
            end
            OP_J, OP_JAL:     cls_o = CLS_J;
            default:          legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM: walks one instruction through fetch/decode/execute,
// drives datapath selects and a shared memory req/ready port, counts retirements.
module mc_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [5:0]       op,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_en,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             ext_ctr,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_sel,
    output logic             retire,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired_cnt
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    instr_cls_e       dec_cls;
    logic             dec_legal;
    logic             dec_ext;
    logic [2:0]       dec_alu_op;
    state_e           boundary;

    mc_opcode_decode u_dec (
        .op_i      (op),
        .cls_o     (dec_cls),
        .legal_o   (dec_legal),
        .ext_ctr_o (dec_ext),
        .alu_op_o  (dec_alu_op)
    );

    // op is only meaningful once the IR has been loaded, so mask it before DECODE
    assign ext_ctr  = dec_ext && (state_q != ST_IDLE) && (state_q != ST_FETCH);
    assign boundary = run ? ST_FETCH : ST_IDLE;
    assign retired_cnt = cnt_q;
    assign cnt_d = retire ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;

    always_comb begin
        state_d    = state_q;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_source  = PCSRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        reg_dst    = REGDST_RT;
        wb_sel     = WB_ALUOUT;
        retire     = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM_SL2;
                if (!dec_legal) begin
                    illegal_op = 1'b1;
                    state_d    = boundary;
                end else begin
                    case (dec_cls)
                        CLS_R:   state_d = ST_EXEC_R;
                        CLS_I:   state_d = ST_EXEC_I;
                        CLS_MEM: state_d = ST_MEM_ADDR;
                        CLS_BR:  state_d = ST_BRANCH;
                        CLS_J:   state_d = ST_JUMP;
                        default: state_d = boundary;
                    endcase
                end
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_RT;
                alu_op    = ALU_FUNCT;
                state_d   = ST_ALU_WB;
            end
            ST_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = dec_alu_op;
                state_d   = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = (dec_cls == CLS_R) ? REGDST_RD : REGDST_RT;
                wb_sel    = WB_ALUOUT;
                retire    = 1'b1;
                state_d   = boundary;
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (op == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                reg_write = 1'b1;
                reg_dst   = REGDST_RT;
                wb_sel    = WB_MDR;
                retire    = 1'b1;
                state_d   = boundary;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = boundary;
                end
            end
            ST_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_RT;
                alu_op    = ALU_SUB;
                pc_source = PCSRC_ALUOUT;
                // beq takes on equal (zero), bne on not-equal
                pc_en     = (alu_zero == (op == OP_BEQ));
                retire    = 1'b1;
                state_d   = boundary;
            end
            ST_JUMP: begin
                pc_source = PCSRC_JUMP;
                pc_en     = 1'b1;
                retire    = 1'b1;
                if (op == OP_JAL) begin
                    reg_write = 1'b1;
                    reg_dst   = REGDST_R31;
                    wb_sel    = WB_PC;
                end
                state_d = boundary;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-cycle vector table for the instruction
// mix, plus hand sequences for reset during a memory read and counter wrap.
module tb_mc_control;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       ext_ctr;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] wb_sel;
        logic       retire;
        logic       illegal_op;
    } out_t;

    typedef struct {
        logic        run;
        logic [5:0]  op;
        logic        rdy;
        logic        zero;
        out_t        exp;
        int unsigned cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [5:0]  op;
    logic        alu_zero;
    logic        mem_ready;

    logic        mem_read, mem_write, i_or_d, ir_write, pc_en;
    logic [1:0]  pc_source, alu_src_b, reg_dst, wb_sel;
    logic        alu_src_a, ext_ctr, reg_write, retire, illegal_op;
    logic [2:0]  alu_op;
    logic [31:0] retired_cnt;

    logic        m4_mem_read, m4_mem_write, m4_i_or_d, m4_ir_write, m4_pc_en;
    logic [1:0]  m4_pc_source, m4_alu_src_b, m4_reg_dst, m4_wb_sel;
    logic        m4_alu_src_a, m4_ext_ctr, m4_reg_write, m4_retire, m4_illegal_op;
    logic [2:0]  m4_alu_op;
    logic [3:0]  m4_retired_cnt;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];
    out_t act;
    out_t o_idle, o_fetch_w, o_fetch, o_dec0, o_dec1;

    always #5 clk = ~clk;

    mc_control #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .op(op), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
        .i_or_d(i_or_d), .ir_write(ir_write), .pc_en(pc_en), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .ext_ctr(ext_ctr), .reg_write(reg_write), .reg_dst(reg_dst), .wb_sel(wb_sel),
        .retire(retire), .illegal_op(illegal_op), .retired_cnt(retired_cnt)
    );

    mc_control #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .run(run), .op(op), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_read(m4_mem_read), .mem_write(m4_mem_write),
        .i_or_d(m4_i_or_d), .ir_write(m4_ir_write), .pc_en(m4_pc_en),
        .pc_source(m4_pc_source), .alu_src_a(m4_alu_src_a), .alu_src_b(m4_alu_src_b),
        .alu_op(m4_alu_op), .ext_ctr(m4_ext_ctr), .reg_write(m4_reg_write),
        .reg_dst(m4_reg_dst), .wb_sel(m4_wb_sel), .retire(m4_retire),
        .illegal_op(m4_illegal_op), .retired_cnt(m4_retired_cnt)
    );

    always_comb begin
        act = {mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source, alu_src_a,
               alu_src_b, alu_op, ext_ctr, reg_write, reg_dst, wb_sel, retire, illegal_op};
    end

    task automatic add(input logic r, input logic [5:0] o, input logic rd,
                       input logic z, input out_t e, input int unsigned c);
        vec_t v;
        v.run = r; v.op = o; v.rdy = rd; v.zero = z; v.exp = e; v.cnt = c;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0; mem_ready = 1'b1; alu_zero = 1'b0; op = 6'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; op = 6'h00; alu_zero = 1'b0; mem_ready = 1'b1;
        o_idle    = '{default: 0};
        o_fetch_w = '{mem_read: 1'b1, alu_src_b: 2'b01, default: 0};
        o_fetch   = '{mem_read: 1'b1, alu_src_b: 2'b01, ir_write: 1'b1, pc_en: 1'b1, default: 0};
        o_dec0    = '{alu_src_b: 2'b11, default: 0};
        o_dec1    = '{alu_src_b: 2'b11, ext_ctr: 1'b1, default: 0};

        // ---- reset asserted in the middle of a stalled lw read ----
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; run = 1'b1; op = OP_LW; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        #1 chk("memrd_req_before_reset", {62'd0, mem_read, i_or_d}, 64'd3);
        #2 rst_n = 1'b0;
        #1 chk("outputs_during_reset", {42'd0, act}, 64'd0);
        chk("cnt_during_reset", {32'd0, retired_cnt}, 64'd0);
        run = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1 chk("idle_after_release", {42'd0, act}, 64'd0);
        chk("cnt_idle_after_release", {32'd0, retired_cnt}, 64'd0);

        // ---- per-cycle vector table: run, op, mem_ready, alu_zero, outputs, count ----
        add(1, OP_ADDI, 1, 0, o_idle, 0);
        add(1, OP_ADDI, 1, 0, o_fetch, 0);
        add(1, OP_ADDI, 1, 0, o_dec1, 0);
        add(1, OP_ADDI, 1, 0, '{alu_src_a: 1'b1, alu_src_b: 2'b10, alu_op: 3'b000, ext_ctr: 1'b1, default: 0}, 0);
        add(1, OP_ADDI, 1, 0, '{reg_write: 1'b1, reg_dst: 2'b00, retire: 1'b1, ext_ctr: 1'b1, default: 0}, 0);
        add(1, OP_ORI, 1, 0, o_fetch, 1);
        add(1, OP_ORI, 1, 0, o_dec0, 1);
        add(1, OP_ORI, 1, 0, '{alu_src_a: 1'b1, alu_src_b: 2'b10, alu_op: 3'b011, default: 0}, 1);
        add(1, OP_ORI, 1, 0, '{reg_write: 1'b1, retire: 1'b1, default: 0}, 1);
        add(1, OP_RTYP, 1, 0, o_fetch, 2);
        add(1, OP_RTYP, 1, 0, o_dec0, 2);
        add(1, OP_RTYP, 1, 0, '{alu_src_a: 1'b1, alu_src_b: 2'b00, alu_op: 3'b111, default: 0}, 2);
        add(1, OP_RTYP, 1, 0, '{reg_write: 1'b1, reg_dst: 2'b01, retire: 1'b1, default: 0}, 2);
        add(1, OP_LW, 1, 0, o_fetch, 3);
        add(1, OP_LW, 1, 0, o_dec1, 3);
        add(1, OP_LW, 1, 0, '{alu_src_a: 1'b1, alu_src_b: 2'b10, ext_ctr: 1'b1, default: 0}, 3);
        for (int i = 0; i < 3; i++)
            add(1, OP_LW, 0, 0, '{mem_read: 1'b1, i_or_d: 1'b1, ext_ctr: 1'b1, default: 0}, 3);
        add(1, OP_LW, 1, 0, '{mem_read: 1'b1, i_or_d: 1'b1, ext_ctr: 1'b1, default: 0}, 3);
        add(1, OP_LW, 1, 0, '{reg_write: 1'b1, wb_sel: 2'b01, retire: 1'b1, ext_ctr: 1'b1, default: 0}, 3);
        add(1, OP_SW, 0, 0, o_fetch_w, 4);
        add(1, OP_SW, 1, 0, o_fetch, 4);
        add(1, OP_SW, 1, 0, o_dec1, 4);
        add(1, OP_SW, 1, 0, '{alu_src_a: 1'b1, alu_src_b: 2'b10, ext_ctr: 1'b1, default: 0}, 4);
        add(1, OP_SW, 0, 0, '{mem_write: 1'b1, i_or_d: 1'b1, ext_ctr: 1'b1, default: 0}, 4);
        add(1, OP_SW, 1, 0, '{mem_write: 1'b1, i_or_d: 1'b1, ext_ctr: 1'b1, retire: 1'b1, default: 0}, 4);
        add(1, OP_BEQ, 1, 1, o_fetch, 5);
        add(1, OP_BEQ, 1, 1, o_dec1, 5);
        add(1, OP_BEQ, 1, 1, '{alu_src_a: 1'b1, alu_op: 3'b001, pc_source: 2'b01, pc_en: 1'b1, retire: 1'b1, ext_ctr: 1'b1, default: 0}, 5);
        add(1, OP_BNE, 1, 1, o_fetch, 6);
        add(1, OP_BNE, 1, 1, o_dec1, 6);
        add(1, OP_BNE, 1, 1, '{alu_src_a: 1'b1, alu_op: 3'b001, pc_source: 2'b01, retire: 1'b1, ext_ctr: 1'b1, default: 0}, 6);
        add(1, OP_JAL, 1, 0, o_fetch, 7);
        add(1, OP_JAL, 1, 0, o_dec0, 7);
        add(1, OP_JAL, 1, 0, '{pc_source: 2'b10, pc_en: 1'b1, reg_write: 1'b1, reg_dst: 2'b10, wb_sel: 2'b10, retire: 1'b1, default: 0}, 7);
        add(1, OP_J, 1, 0, o_fetch, 8);
        add(1, OP_J, 1, 0, o_dec0, 8);
        add(0, OP_J, 1, 0, '{pc_source: 2'b10, pc_en: 1'b1, retire: 1'b1, default: 0}, 8);
        add(0, OP_J, 1, 0, o_idle, 9);
        add(1, 6'h3F, 1, 0, o_idle, 9);
        add(1, 6'h3F, 1, 0, o_fetch, 9);
        add(1, 6'h3F, 1, 0, '{alu_src_b: 2'b11, illegal_op: 1'b1, default: 0}, 9);
        add(0, OP_XORI, 1, 0, o_fetch, 9);
        add(0, OP_XORI, 1, 0, o_dec0, 9);
        add(0, OP_XORI, 1, 0, '{alu_src_a: 1'b1, alu_src_b: 2'b10, alu_op: 3'b100, default: 0}, 9);
        add(0, OP_XORI, 1, 0, '{reg_write: 1'b1, retire: 1'b1, default: 0}, 9);
        add(0, OP_XORI, 1, 0, o_idle, 10);
        add(0, OP_XORI, 1, 0, o_idle, 10);

        do_reset();
        foreach (vecs[i]) begin
            @(negedge clk);
            run = vecs[i].run; op = vecs[i].op;
            mem_ready = vecs[i].rdy; alu_zero = vecs[i].zero;
            #1;
            checks++;
            if (act !== vecs[i].exp) begin
                errors++;
                $display("FAIL vec%0d outputs: got %h, want %h", i, act, vecs[i].exp);
            end
            checks++;
            if (retired_cnt !== vecs[i].cnt) begin
                errors++;
                $display("FAIL vec%0d retired_cnt: got %0d, want %0d", i, retired_cnt, vecs[i].cnt);
            end
        end

        // ---- counter wrap: 16 back-to-back j instructions, 3 cycles each ----
        do_reset();
        run = 1'b1; op = OP_J; mem_ready = 1'b1;
        repeat (46) @(negedge clk);
        #1 chk("cnt4_after_15", {60'd0, m4_retired_cnt}, 64'd15);
        repeat (3) @(negedge clk);
        #1 chk("cnt4_wrap_after_16", {60'd0, m4_retired_cnt}, 64'd0);
        chk("cnt32_after_16", {32'd0, retired_cnt}, 64'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
Multi-cycle control sequencer for the MIPS-subset datapath. It replaces single-cycle decode with a state machine that takes one instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK states. It drives the datapath mux selects, register enables and a shared instruction/data memory through a req/ready handshake. It also produces a retirement pulse and a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  enable; sampled only in IDLE and at instruction boundary
op  in  6  instruction[31:26], from IR (valid from DECODE onward)
alu_zero  in  1  ALU zero flag (valid in BRANCH state)
mem_ready  in  1  memory completes current read/write this cycle
mem_read  out  1  memory read request, held until mem_ready
mem_write  out  1  memory write request, held until mem_ready
i_or_d  out  1  0=PC address, 1=ALUOut address
ir_write  out  1  load IR
pc_en  out  1  PC write enable (unconditional or branch-taken)
pc_source  out  2  00=ALU result, 01=ALUOut (branch target), 10=jump target
alu_src_a  out  1  0=PC, 1=rs
alu_src_b  out  2  00=rt, 01=const 4, 10=ext imm, 11=ext imm<<2
alu_op  out  3  000 add, 001 sub/compare, 010 and, 011 or, 100 xor, 110 lui, 111 R-type funct
ext_ctr  out  1  1=sign-extend imm, 0=zero-extend
reg_write  out  1  register file write enable
reg_dst  out  2  00=rt, 01=rd, 10=r31
wb_sel  out  2  00=ALUOut, 01=MDR, 10=PC (link)
retire  out  1  one-cycle pulse when instruction completes
illegal_op  out  1  one-cycle pulse on unsupported opcode in DECODE
retired_cnt  out  CNT_W  count of retired instructions

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0, retired_cnt=0. Any pending memory request is dropped immediately. The enum default is IDLE.
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JUMP.
- IDLE: go to FETCH when run=1.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00.
  - Stays in FETCH while mem_ready=0.
  - In the cycle mem_ready=1: ir_write=1, pc_en=1 (PC+4), next=DECODE.
- DECODE:
  - Branch target precompute: alu_src_a=0, alu_src_b=11, alu_op=000.
  - Next state by op: 000000->EXEC_R; addi/addiu/andi/ori/xori/lui/slti/sltiu->EXEC_I; lw/sw->MEM_ADDR; beq/bne->BRANCH; j/jal->JUMP.
  - Any other op: illegal_op=1, next=FETCH (or IDLE if run=0). PC is already advanced. No retire.
- ext_ctr=1 for addi, addiu, slti, sltiu, lw, sw, beq, bne; 0 for andi, ori, xori, lui. It is held from DECODE to instruction end.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=111 -> ALU_WB with reg_dst=01.
- EXEC_I: alu_src_a=1, alu_src_b=10. alu_op is: addi/addiu 000, andi 010, ori 011, xori 100, lui 110, slti/sltiu 001. Next is ALU_WB with reg_dst=00.
- ALU_WB: reg_write=1, wb_sel=00, retire.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000. lw->MEM_RD, sw->MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Waits for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, wb_sel=01, retire.
- MEM_WR: mem_write=1, i_or_d=1. Waits for mem_ready. Retires in the mem_ready cycle.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=001, pc_source=01.
  - pc_en = (alu_zero == (op==beq)), so beq is taken on zero=1 and bne on zero=0.
  - Retire.
- JUMP: pc_source=10, pc_en=1, retire. For jal also reg_write=1, reg_dst=10, wb_sel=10.
- Instruction boundary: after a retiring state (or illegal DECODE), next=FETCH if run=1, else IDLE. Dropping run mid-instruction never aborts it.
- Cycle counts with mem_ready tied 1: R/I-ALU 4, lw 5, sw 4, beq/bne 3, j/jal 3. Each wait cycle on mem_ready adds 1.
- mem_read and mem_write are never both 1. Request signals stay stable until mem_ready.
- retired_cnt increments on each retire pulse and wraps to 0 after all-ones.
- Outputs are decoded from the registered state plus op. Only ir_write, pc_en (FETCH) and the MEM_WR retire pulse depend on mem_ready.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode localparams: rtyp, addi, addiu, andi, ori, xori, lui, lw, sw, beq, bne, slti, sltiu, j, jal;
  - ALU op codes;
  - state enum;
  - encodings for alu_src_b, pc_source, reg_dst, wb_sel.
- Sub-module mc_opcode_decode (combinational) maps op to {instr class, legal, ext_ctr, alu_op}. The FSM and counter stay in mc_control.

Test Plan:
- Reset/idle: rst_n=0 mid-MEM_RD with mem_read=1 -> all outputs 0 immediately; after release with run=0 the block stays IDLE and retired_cnt=0.
- addi, mem_ready=1: FETCH, DECODE, EXEC_I, ALU_WB in 4 cycles -> alu_op=000, ext_ctr=1, reg_dst=00, reg_write=1 on cycle 4, retire=1, retired_cnt=1.
- lw with mem_ready low for 3 cycles in MEM_RD -> mem_read=1, i_or_d=1 held 4 cycles, 8 cycles total, then MEM_WB with wb_sel=01.
- beq then bne, both with alu_zero=1 -> beq pc_en=1 pc_source=01; bne pc_en=0; both retire in 3 cycles.
- jal -> JUMP with pc_en=1, pc_source=10, reg_write=1, reg_dst=10, wb_sel=10; j -> reg_write=0.
- op=6'b111111 -> illegal_op pulses in DECODE, next FETCH, retired_cnt unchanged. Separately, with CNT_W=4, after 16 retires retired_cnt wraps to 0.
